req_ack_arbiter: RTL and testbench

REQ_ACK_ARBITER -- requirements
Module: req_ack_arbiter

---
 rtl/req_ack_arbiter_if.sv | 26 ++
 rtl/req_ack_arbiter.sv | 133 +++++++++++++
 tb/tb_req_ack_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/req_ack_arbiter_if.sv
// Handshake bundle between requesters, the round-robin arbiter and the shared resource.
// The master modport is the arbiter side; slave is the requester/resource side.
interface req_ack_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] done;
    logic             res_req;
    logic             res_ack;
    logic             timeout_err;
    logic [IDW-1:0]   err_id;
    logic             busy;

    modport master (
        input  req, res_ack,
        output gnt, done, res_req, timeout_err, err_id, busy
    );

    modport slave (
        output req, res_ack,
        input  gnt, done, res_req, timeout_err, err_id, busy
    );
endinterface

// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter granting one requester at a time access to a shared resource
// through a 4-phase res_req/res_ack handshake with a wait timeout.
//
// state    | meaning
// IDLE     | no grant; arbitrate among pending requests
// WAIT_ACK | res_req high, waiting for res_ack or timeout
// RELEASE  | handshake over, hold gnt until winner and resource both drop
module req_ack_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    req_ack_arbiter_if.master bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} state_t;

    state_t           state, state_d;
    logic [IDW-1:0]   winner, winner_d;
    logic [IDW-1:0]   last_winner, last_winner_d;
    logic [IDW-1:0]   err_id_q, err_id_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             res_req_q, res_req_d;
    logic             tmo_q, tmo_d;
    logic             busy_q, busy_d;
    logic [IDW-1:0]   pick;
    logic             found;

    // Search starts just past the previous winner so every requester gets a turn.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_w;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx   = (int'(last_winner) + i) % N_REQ;
            idx_w = IDW'(idx);
            if (!found && bus.req[idx_w]) begin
                found = 1'b1;
                pick  = idx_w;
            end
        end
    end

    always_comb begin
        state_d       = state;
        winner_d      = winner;
        last_winner_d = last_winner;
        err_id_d      = err_id_q;
        cnt_d         = cnt;
        gnt_d         = gnt_q;
        done_d        = '0;
        res_req_d     = res_req_q;
        tmo_d         = 1'b0;
        busy_d        = busy_q;
        case (state)
            IDLE: begin
                if (found) begin
                    winner_d  = pick;
                    gnt_d     = N_REQ'(1) << pick;
                    res_req_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // An ack arriving on the last allowed cycle still counts as success.
                if (bus.res_ack) begin
                    res_req_d = 1'b0;
                    done_d    = N_REQ'(1) << winner;
                    state_d   = RELEASE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    res_req_d = 1'b0;
                    tmo_d     = 1'b1;
                    err_id_d  = winner;
                    state_d   = RELEASE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            RELEASE: begin
                if (!bus.req[winner] && !bus.res_ack) begin
                    gnt_d         = '0;
                    busy_d        = 1'b0;
                    last_winner_d = winner;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            winner      <= '0;
            last_winner <= IDW'(N_REQ - 1);
            err_id_q    <= '0;
            cnt         <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            res_req_q   <= 1'b0;
            tmo_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_d;
            winner      <= winner_d;
            last_winner <= last_winner_d;
            err_id_q    <= err_id_d;
            cnt         <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            res_req_q   <= res_req_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.res_req     = res_req_q;
    assign bus.timeout_err = tmo_q;
    assign bus.err_id      = err_id_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_req_ack_arbiter.sv
// Directed bench for req_ack_arbiter (N_REQ=4, TIMEOUT=16) with hand-computed expectations.
module tb_req_ack_arbiter;
    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   hi_cnt;

    req_ack_arbiter_if #(.N_REQ(N_REQ)) bus ();

    req_ack_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then check the always-true properties on the fresh outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) begin
            hi_cnt = bus.res_req ? hi_cnt + 1 : 0;
            chk("gnt_onehot0", 8'($onehot0(bus.gnt)), 8'd1);
            chk("done_onehot0", 8'($onehot0(bus.done)), 8'd1);
            chk("done_has_gnt", 8'(bus.done & ~bus.gnt), 8'd0);
            chk("res_req_bounded", 8'(hi_cnt <= TIMEOUT), 8'd1);
        end else begin
            hi_cnt = 0;
        end
    endtask

    initial begin
        int  hi;
        int  nt;
        int  nd;
        logic [3:0] exp_g;
        errors      = 0;
        checks      = 0;
        hi_cnt      = 0;
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.res_ack = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 8'(bus.gnt), 8'h0);
        chk("rst_res_req", 8'(bus.res_req), 8'h0);
        chk("rst_busy", 8'(bus.busy), 8'h0);
        chk("rst_done", 8'(bus.done), 8'h0);
        chk("rst_tmo", 8'(bus.timeout_err), 8'h0);
        chk("rst_err_id", 8'(bus.err_id), 8'h0);

        // single requester, ack three cycles after res_req
        rst_n   = 1'b1;
        bus.req = 4'b0001;
        tick();
        chk("t1_gnt", 8'(bus.gnt), 8'h1);
        chk("t1_res_req", 8'(bus.res_req), 8'h1);
        chk("t1_busy", 8'(bus.busy), 8'h1);
        tick();
        tick();
        chk("t1_wait_gnt", 8'(bus.gnt), 8'h1);
        chk("t1_wait_done", 8'(bus.done), 8'h0);
        bus.res_ack = 1'b1;
        tick();
        chk("t1_done", 8'(bus.done), 8'h1);
        chk("t1_res_req_low", 8'(bus.res_req), 8'h0);
        chk("t1_rel_gnt", 8'(bus.gnt), 8'h1);
        bus.res_ack = 1'b0;
        bus.req     = 4'b0000;
        tick();
        chk("t1_done_pulse", 8'(bus.done), 8'h0);
        chk("t1_idle_gnt", 8'(bus.gnt), 8'h0);
        chk("t1_idle_busy", 8'(bus.busy), 8'h0);

        // all requesting: order 0,1,2,3,0 after reset
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            tick();
            chk("rr_gnt", 8'(bus.gnt), 8'(exp_g));
            chk("rr_res_req", 8'(bus.res_req), 8'h1);
            tick();
            bus.res_ack = 1'b1;
            tick();
            chk("rr_done", 8'(bus.done), 8'(exp_g));
            bus.res_ack = 1'b0;
            bus.req     = 4'b1111 & ~exp_g;
            tick();
            chk("rr_idle_gnt", 8'(bus.gnt), 8'h0);
            chk("rr_idle_busy", 8'(bus.busy), 8'h0);
            bus.req = 4'b1111;
        end
        bus.req = 4'b0000;
        tick();

        // timeout: requester 2, ack never rises
        bus.req = 4'b0100;
        tick();
        chk("to_gnt", 8'(bus.gnt), 8'h4);
        hi = 0;
        nd = 0;
        nt = 0;
        for (int c = 0; c < 40 && bus.res_req; c++) begin
            hi++;
            if (bus.done != 0) nd++;
            tick();
        end
        chk("to_res_req_cycles", 8'(hi), 8'd16);
        chk("to_err", 8'(bus.timeout_err), 8'h1);
        chk("to_err_id", 8'(bus.err_id), 8'h2);
        chk("to_done", 8'(bus.done), 8'h0);
        chk("to_no_done_before", 8'(nd), 8'd0);
        tick();
        chk("to_err_pulse", 8'(bus.timeout_err), 8'h0);
        chk("to_rel_gnt", 8'(bus.gnt), 8'h4);
        bus.req = 4'b0000;
        tick();
        chk("to_idle_gnt", 8'(bus.gnt), 8'h0);

        // ack on the 16th wait cycle wins over timeout
        bus.req = 4'b0010;
        tick();
        chk("late_gnt", 8'(bus.gnt), 8'h2);
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.timeout_err) nt++;
        end
        chk("late_res_req", 8'(bus.res_req), 8'h1);
        bus.res_ack = 1'b1;
        tick();
        chk("late_done", 8'(bus.done), 8'h2);
        chk("late_tmo", 8'(bus.timeout_err), 8'h0);
        chk("late_no_tmo_before", 8'(nt), 8'd0);
        chk("late_err_id_held", 8'(bus.err_id), 8'h2);
        bus.res_ack = 1'b0;
        bus.req     = 4'b0000;
        tick();
        chk("late_idle", 8'(bus.busy), 8'h0);

        // reset during WAIT_ACK
        bus.req = 4'b0001;
        tick();
        chk("mid_gnt", 8'(bus.gnt), 8'h1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_gnt", 8'(bus.gnt), 8'h0);
        chk("mid_rst_res_req", 8'(bus.res_req), 8'h0);
        chk("mid_rst_busy", 8'(bus.busy), 8'h0);
        chk("mid_rst_done", 8'(bus.done), 8'h0);
        chk("mid_rst_err_id", 8'(bus.err_id), 8'h0);
        rst_n   = 1'b1;
        bus.req = 4'b1000;
        tick();
        chk("post_rst_gnt3", 8'(bus.gnt), 8'h8);
        bus.res_ack = 1'b1;
        tick();
        chk("post_rst_done3", 8'(bus.done), 8'h8);
        bus.res_ack = 1'b0;
        bus.req     = 4'b0000;
        tick();
        bus.req = 4'b1001;
        tick();
        chk("prio0_gnt", 8'(bus.gnt), 8'h1);
        bus.res_ack = 1'b1;
        tick();
        chk("prio0_done", 8'(bus.done), 8'h1);
        // winner drops but resource still acks: grant must stay
        bus.req = 4'b1000;
        tick();
        chk("hold_gnt_ack_high", 8'(bus.gnt), 8'h1);
        chk("hold_busy", 8'(bus.busy), 8'h1);
        bus.res_ack = 1'b0;
        tick();
        chk("hold_release", 8'(bus.gnt), 8'h0);
        tick();
        chk("next_gnt3", 8'(bus.gnt), 8'h8);
        bus.req = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
